// File: rtl/dram_ctrl_pkg.sv
// Shared types and default sizing for the DRAM ping-pong controller.
package dram_ctrl_pkg;

  localparam int unsigned IoWidthDflt   = 16;
  localparam int unsigned AddrWidthDflt = 6;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StSwap
  } state_e;

endpackage

// File: rtl/dram_scan_counter.sv
// Modulo-IO_WIDTH scan address counter; wrap_o flags the last address of a pass.
module dram_scan_counter
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned IO_WIDTH   = IoWidthDflt,
  parameter int unsigned ADDR_WIDTH = AddrWidthDflt
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  output logic [ADDR_WIDTH-1:0] count_o,
  output logic                  wrap_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(IO_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] count_d, count_q;

  assign wrap_o  = en_i && (count_q == LastAddr);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dram_pingpong_ctrl.sv
// Ping-pong bank controller: scans in[] into the write bank while shadowing the read bank.
// Define DRAM_PINGPONG_AUTOSWAP_EN to swap banks after every pass regardless of swap_req.
module dram_pingpong_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned IO_WIDTH   = IoWidthDflt,
  parameter int unsigned ADDR_WIDTH = AddrWidthDflt
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IO_WIDTH-1:0]   in,
  output logic [IO_WIDTH-1:0]   out,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  bank,
  output logic [ADDR_WIDTH:0]   ram_wa,
  output logic [ADDR_WIDTH:0]   ram_ra,
  output logic                  ram_we,
  output logic                  ram_d,
  input  logic                  ram_q,
  output logic                  pass_done
);

  state_e                state_d, state_q;
  logic                  rst_sync_q;
  logic                  bank_d, bank_q;
  logic [IO_WIDTH-1:0]   out_d, out_q;
  logic [IO_WIDTH-1:0]   shadow_d, shadow_q;
  logic                  swap_ack_d, swap_ack_q;
  logic                  ram_we_d, ram_we_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  cnt_en;
  logic                  cnt_wrap;
  logic                  swap_take;

`ifdef DRAM_PINGPONG_AUTOSWAP_EN
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign swap_take       = 1'b1;
`else
  assign swap_take = swap_req;
`endif

  assign cnt_en = (state_q == StScan);

  dram_scan_counter #(
    .IO_WIDTH  (IO_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scan_counter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (cnt_en),
    .count_o(addr),
    .wrap_o (cnt_wrap)
  );

  // Releasing reset through a flop gives one extra IDLE cycle before scanning starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    out_d    = out_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (rst_sync_q) begin
          state_d = StScan;
        end
      end
      StScan: begin
        for (int i = 0; i < IO_WIDTH; i++) begin
          if (ADDR_WIDTH'(i) == addr) begin
            shadow_d[i] = ram_q;
          end
        end
        // The last bit comes straight from this cycle's ram_q via shadow_d.
        if (cnt_wrap) begin
          out_d = shadow_d;
          if (swap_take) begin
            state_d = StSwap;
            bank_d  = ~bank_q;
          end
        end
      end
      StSwap: begin
        state_d = StScan;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    ram_we_d   = (state_d == StScan);
    swap_ack_d = (state_d == StSwap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bank_q     <= 1'b0;
      out_q      <= '0;
      shadow_q   <= '0;
      swap_ack_q <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      out_q      <= out_d;
      shadow_q   <= shadow_d;
      swap_ack_q <= swap_ack_d;
      ram_we_q   <= ram_we_d;
    end
  end

  assign out       = out_q;
  assign bank      = bank_q;
  assign swap_ack  = swap_ack_q;
  assign ram_we    = ram_we_q;
  assign ram_d     = ram_we_q & (|(in & (IO_WIDTH'(1) << addr)));
  assign ram_wa    = {bank_q, addr};
  assign ram_ra    = {~bank_q, addr};
  assign pass_done = cnt_wrap;

endmodule

// File: tb/tb_dram_pingpong_ctrl.sv
// Randomised bench for dram_pingpong_ctrl with a pass-level reference model and a bit RAM.
module tb_dram_pingpong_ctrl;

  localparam int W        = 16;
  localparam int AW       = 6;
  localparam int IW       = $clog2(W);
  localparam int MemDepth = 2 << AW;
`ifdef DRAM_PINGPONG_AUTOSWAP_EN
  localparam bit AutoSwap = 1'b1;
`else
  localparam bit AutoSwap = 1'b0;
`endif

  typedef logic [AW:0] maddr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in;
  logic [W-1:0]  out;
  logic          swap_req;
  logic          swap_ack;
  logic          bank;
  logic [AW:0]   ram_wa;
  logic [AW:0]   ram_ra;
  logic          ram_we;
  logic          ram_d;
  logic          ram_q;
  logic          pass_done;

  always #5 clk = ~clk;

  dram_pingpong_ctrl #(
    .IO_WIDTH  (W),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .out      (out),
    .swap_req (swap_req),
    .swap_ack (swap_ack),
    .bank     (bank),
    .ram_wa   (ram_wa),
    .ram_ra   (ram_ra),
    .ram_we   (ram_we),
    .ram_d    (ram_d),
    .ram_q    (ram_q),
    .pass_done(pass_done)
  );

  // Bit-wide dual-port RAM with asynchronous read port.
  logic         mem [MemDepth];
  logic         load_en;
  logic [W-1:0] load_word;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < MemDepth; i++) mem[maddr_t'(i)] <= 1'b0;
      for (int i = 0; i < W; i++) mem[maddr_t'(MemDepth / 2 + i)] <= load_word[IW'(i)];
    end else if (ram_we) begin
      mem[ram_wa] <= ram_d;
    end
  end

  assign ram_q = mem[ram_ra];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: m_pos = -2 held/just released, -1 idle, 0..W-1 scan position, W = swap cycle.
  int           m_pos;
  logic         m_bank;
  logic [W-1:0] m_out;
  logic [W-1:0] m_snap;

  task automatic model_reset();
    m_pos  = -2;
    m_bank = 1'b0;
    m_out  = '0;
  endtask

  task automatic take_snap();
    for (int i = 0; i < W; i++) m_snap[IW'(i)] = mem[{~m_bank, AW'(i)}];
  endtask

  // Predicts the cycle after the coming rising edge, given the inputs now applied.
  task automatic model_advance();
    if (!rst_n) return;
    if (m_pos == -2) begin
      m_pos = -1;
    end else if (m_pos == W - 1) begin
      m_out = m_snap;
      if (AutoSwap || swap_req) begin
        m_pos  = W;
        m_bank = ~m_bank;
      end else begin
        m_pos = 0;
        take_snap();
      end
    end else if (m_pos == -1 || m_pos == W) begin
      m_pos = 0;
      take_snap();
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_cycle();
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic          exp_d;
    exp_we   = (m_pos >= 0) && (m_pos < W);
    exp_addr = exp_we ? AW'(m_pos) : '0;
    exp_d    = exp_we ? in[IW'(m_pos)] : 1'b0;
    check_eq("ram_we", 32'(ram_we), 32'(exp_we));
    check_eq("pass_done", 32'(pass_done), 32'(m_pos == W - 1));
    check_eq("swap_ack", 32'(swap_ack), 32'(m_pos == W));
    check_eq("bank", 32'(bank), 32'(m_bank));
    check_eq("out", 32'(out), 32'(m_out));
    check_eq("ram_wa", 32'(ram_wa), 32'({m_bank, exp_addr}));
    check_eq("ram_ra", 32'(ram_ra), 32'({~m_bank, exp_addr}));
    check_eq("ram_d", 32'(ram_d), 32'(exp_d));
    check_eq("bank_split", 32'(ram_wa[AW] ^ ram_ra[AW]), 32'd1);
  endtask

  task automatic tick();
    model_advance();
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    int           n;
    logic [W-1:0] word;
    rst_n     = 1'b1;
    in        = '0;
    swap_req  = 1'b0;
    load_en   = 1'b1;
    load_word = 16'h96A5;
    #1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_cycle();
    load_en = 1'b0;

    // Release: first write cycle two edges later.
    rst_n = 1'b1;
    in    = 16'h1234;
    n     = 0;
    while (n < 10) begin
      tick();
      n++;
      if (ram_we) break;
    end
    check_eq("first_we_latency", 32'(n), 32'd2);

    // First pass reads preloaded bank 1 and fills bank 0.
    for (int i = 0; i < W; i++) tick();
    check_eq("pass1_out", 32'(out), 32'h96A5);
    for (int i = 0; i < W; i++) word[IW'(i)] = mem[{1'b0, AW'(i)}];
    check_eq("bank0_word", 32'(word), 32'h1234);

    // Swap request raised mid-pass, deferred to the wrap.
    n = 0;
    while (m_pos != 5 && n < 40) begin
      tick();
      n++;
    end
    swap_req = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (swap_ack) break;
    end
    check_eq("swap_ack_latency", 32'(n), 32'd11);
`ifndef DRAM_PINGPONG_AUTOSWAP_EN
    check_eq("bank_after_swap", 32'(bank), 32'd1);
`endif
    swap_req = 1'b0;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (pass_done) break;
    end
    tick();
`ifndef DRAM_PINGPONG_AUTOSWAP_EN
    check_eq("out_after_swap", 32'(out), 32'h1234);
`endif

    // Abort a pass at address 9.
    n = 0;
    while (m_pos != 9 && n < 40) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("abort_out_cleared", 32'(out), 32'd0);
    check_eq("abort_no_pass_done", 32'(pass_done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 1000; c++) begin
      if ($urandom_range(0, 15) == 0) in = W'($urandom);
      if ($urandom_range(0, 7) == 0) swap_req = ~swap_req;
      if (rst_n && $urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else if (!rst_n && $urandom_range(0, 1) == 0) begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
